// File: rtl/ftdi_245_tx.sv
// Write engine for the FTDI 245 synchronous FIFO bus: 2-entry skid input, word register, arbitrated bursts.
// Define FTDI_TX_BE_EN to carry itkeep through to ftdi_be and discard all-zero-keep beats.
module ftdi_245_tx #(
  parameter int BYTES     = 1,
  parameter int MAX_BURST = 256,
  parameter int CW        = 9
) (
  input  logic                 rstn,
  input  logic                 iclk,
  input  logic                 itvalid,
  output logic                 itready,
  input  logic [8*BYTES-1:0]   itdata,
  input  logic [BYTES-1:0]     itkeep,
  output logic                 tx_req,
  input  logic                 tx_gnt,
  input  logic                 ftdi_txe_n,
  output logic                 ftdi_wr_n,
  output logic                 ftdi_oe,
  output logic [8*BYTES-1:0]   ftdi_data,
  output logic [BYTES-1:0]     ftdi_be
);

  localparam int W = 8 * BYTES;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_REQ   = 3'd1;
  localparam logic [2:0] S_TURN  = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_END   = 3'd4;

  logic [2:0]              state_q, state_d;
  logic [1:0][W-1:0]       sk_data_q, sk_data_d;
  logic [1:0][BYTES-1:0]   sk_keep_q, sk_keep_d;
  logic [1:0]              sk_cnt_q, sk_cnt_d;
  logic [W-1:0]            w_data_q, w_data_d;
  logic [BYTES-1:0]        w_keep_q, w_keep_d;
  logic                    w_valid_q, w_valid_d;
  logic [CW-1:0]           burst_q, burst_d;
  logic                    itready_q, itready_d;
  logic                    tx_req_q, tx_req_d;
  logic                    wr_n_q, wr_n_d;
  logic                    oe_q, oe_d;
  logic [BYTES-1:0]        be_q, be_d;

  logic                    keep_ok;
  logic                    accept;
  logic                    push;
  logic                    load;
  logic [CW-1:0]           burst_inc;

`ifdef FTDI_TX_BE_EN
  assign keep_ok = |itkeep;
`else
  logic unused_keep;
  assign keep_ok     = 1'b1;
  assign unused_keep = ^w_keep_q;
`endif

  always_comb begin
    state_d   = state_q;
    sk_data_d = sk_data_q;
    sk_keep_d = sk_keep_q;
    w_data_d  = w_data_q;
    w_keep_d  = w_keep_q;
    w_valid_d = w_valid_q;
    burst_d   = burst_q;

    accept    = !wr_n_q && !ftdi_txe_n;
    push      = itvalid && itready_q && keep_ok;
    // The word register refills from the skid head whenever it is (or is about to be) empty
    // while the bus is ours, so an un-accepted word survives a lost grant untouched.
    load      = ((state_q == S_TURN) || (state_q == S_WRITE)) &&
                (!w_valid_q || accept) && (sk_cnt_q != 2'd0);
    burst_inc = burst_q + CW'(1);

    if (accept) w_valid_d = 1'b0;
    if (load) begin
      w_data_d  = sk_data_q[0];
      w_keep_d  = sk_keep_q[0];
      w_valid_d = 1'b1;
      sk_data_d[0] = sk_data_q[1];
      sk_keep_d[0] = sk_keep_q[1];
    end

    if (push) begin
      if ((sk_cnt_q == 2'd1) && !load) begin
        sk_data_d[1] = itdata;
        sk_keep_d[1] = itkeep;
      end else begin
        sk_data_d[0] = itdata;
        sk_keep_d[0] = itkeep;
      end
    end
    sk_cnt_d  = sk_cnt_q + {1'b0, push} - {1'b0, load};
    itready_d = (sk_cnt_d <= 2'd1);

    if ((state_q == S_WRITE) && accept) burst_d = burst_inc;

    case (state_q)
      S_IDLE:  if ((sk_cnt_q != 2'd0) || w_valid_q) state_d = S_REQ;
      S_REQ:   if (tx_gnt) state_d = S_TURN;
      S_TURN:  state_d = S_WRITE;
      S_WRITE: begin
        if ((accept && (burst_inc == CW'(MAX_BURST))) ||
            (!w_valid_d && (sk_cnt_d == 2'd0)) || !tx_gnt)
          state_d = S_END;
      end
      S_END: begin
        burst_d = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    tx_req_d = (state_d == S_REQ) || (state_d == S_TURN) || (state_d == S_WRITE);
    oe_d     = (state_d == S_TURN) || (state_d == S_WRITE);
    wr_n_d   = !((state_d == S_WRITE) && w_valid_d);
`ifdef FTDI_TX_BE_EN
    be_d     = oe_d ? w_keep_d : '0;
`else
    be_d     = {BYTES{oe_d}};
`endif
  end

  always_ff @(posedge iclk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= S_IDLE;
      sk_data_q <= '0;
      sk_keep_q <= '0;
      sk_cnt_q  <= '0;
      w_data_q  <= '0;
      w_keep_q  <= '0;
      w_valid_q <= 1'b0;
      burst_q   <= '0;
      itready_q <= 1'b0;
      tx_req_q  <= 1'b0;
      wr_n_q    <= 1'b1;
      oe_q      <= 1'b0;
      be_q      <= '0;
    end else begin
      state_q   <= state_d;
      sk_data_q <= sk_data_d;
      sk_keep_q <= sk_keep_d;
      sk_cnt_q  <= sk_cnt_d;
      w_data_q  <= w_data_d;
      w_keep_q  <= w_keep_d;
      w_valid_q <= w_valid_d;
      burst_q   <= burst_d;
      itready_q <= itready_d;
      tx_req_q  <= tx_req_d;
      wr_n_q    <= wr_n_d;
      oe_q      <= oe_d;
      be_q      <= be_d;
    end
  end

  assign itready   = itready_q;
  assign tx_req    = tx_req_q;
  assign ftdi_wr_n = wr_n_q;
  assign ftdi_oe   = oe_q;
  assign ftdi_data = w_data_q;
  assign ftdi_be   = be_q;

endmodule

// File: tb/tb_ftdi_245_tx.sv
// Bench for ftdi_245_tx: in-order word scoreboard plus bus-protocol rules, with directed timing tables.
module tb_ftdi_245_tx;
  localparam int BYTES     = 4;
  localparam int MAX_BURST = 4;
  localparam int CW        = 3;
  localparam int W         = 8 * BYTES;
`ifdef FTDI_TX_BE_EN
  localparam bit BE_EN = 1'b1;
`else
  localparam bit BE_EN = 1'b0;
`endif

  typedef logic [BYTES+W-1:0] word_t;

  logic rstn, iclk, itvalid, itready, tx_req, tx_gnt, ftdi_txe_n, ftdi_wr_n, ftdi_oe;
  logic [W-1:0]     itdata, ftdi_data;
  logic [BYTES-1:0] itkeep, ftdi_be;

  ftdi_245_tx #(.BYTES(BYTES), .MAX_BURST(MAX_BURST), .CW(CW)) dut (
    .rstn(rstn), .iclk(iclk), .itvalid(itvalid), .itready(itready),
    .itdata(itdata), .itkeep(itkeep), .tx_req(tx_req), .tx_gnt(tx_gnt),
    .ftdi_txe_n(ftdi_txe_n), .ftdi_wr_n(ftdi_wr_n), .ftdi_oe(ftdi_oe),
    .ftdi_data(ftdi_data), .ftdi_be(ftdi_be)
  );

  initial iclk = 1'b0;
  always #5 iclk = ~iclk;

  int n_cmp = 0;
  int n_bad = 0;

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  // Reference model: words the chip still owes us, in order, plus burst bookkeeping.
  word_t model_q[$];
  int    burst_log[$];
  int    burst_w  = 0;
  int    low_run  = 100;
  int    n_writes = 0;
  word_t cmp_w;

  logic p_rstn = 1'b0;
  logic p_vld, p_rdy, p_wrn, p_txe, p_gnt, p_req, p_oe;
  logic [W-1:0]     p_din, p_dout;
  logic [BYTES-1:0] p_kin, p_be;

  always @(negedge iclk) begin
    if (!rstn) begin
      model_q.delete();
      burst_w = 0;
      low_run = 100;
      chk("rst_ctrl", {ftdi_wr_n, ftdi_oe, tx_req, itready}, 4'b1000);
      chk("rst_bus", {ftdi_be, ftdi_data}, 0);
    end else if (p_rstn) begin
      if (!p_wrn && !p_txe) begin
        n_writes++;
        chk("wr_pending", model_q.size() != 0, 1);
        if (model_q.size() != 0) begin
          cmp_w = model_q.pop_front();
          chk("wr_data", p_dout, cmp_w[W-1:0]);
          chk("wr_be", p_be, BE_EN ? cmp_w[W +: BYTES] : {BYTES{1'b1}});
        end
        burst_w++;
        chk("burst_len", burst_w <= MAX_BURST, 1);
      end
      if (p_vld && p_rdy && (!BE_EN || p_kin != '0)) model_q.push_back({p_kin, p_din});
      if (p_req && !tx_req) begin
        burst_log.push_back(burst_w);
        burst_w = 0;
      end
      if (!p_wrn && p_txe && p_gnt) begin
        chk("stall_wrn", ftdi_wr_n, 0);
        chk("stall_data", ftdi_data, p_dout);
        chk("stall_be", ftdi_be, p_be);
      end
      if (!ftdi_wr_n) chk("wr_ctx", {ftdi_oe, tx_req, p_oe}, 3'b111);
      if (ftdi_oe) chk("oe_req", tx_req, 1);
      if (ftdi_oe && !p_oe) chk("turn", {p_req, p_gnt, ftdi_wr_n}, 3'b111);
      if (!ftdi_oe && p_oe) chk("end_req", tx_req, 0);
      if (tx_req && !p_req) chk("req_gap", low_run >= 2, 1);
      low_run = tx_req ? 0 : low_run + 1;
      if (!BE_EN) chk("be_oe", ftdi_be, ftdi_oe ? {BYTES{1'b1}} : {BYTES{1'b0}});
      else if (!ftdi_oe) chk("be_idle", ftdi_be, 0);
      if (!itready) chk("rdy_low", model_q.size() >= 2, 1);
    end
    p_rstn = rstn;  p_vld = itvalid; p_rdy = itready; p_wrn = ftdi_wr_n;
    p_txe  = ftdi_txe_n; p_gnt = tx_gnt; p_req = tx_req; p_oe = ftdi_oe;
    p_din  = itdata; p_kin = itkeep; p_dout = ftdi_data; p_be = ftdi_be;
  end

  // Stimulus: source queue, arbiter and chip back-pressure, all driven 1 time unit after the edge.
  word_t src_q[$];
  bit    gnt_rand = 0, txe_rand = 0, src_rand = 0;
  int    gdelay   = 0;
  logic  rdy_prev = 1'b0;

  task automatic step();
    @(posedge iclk); #1;
    if (itvalid && rdy_prev) void'(src_q.pop_front());
    if (!itvalid || rdy_prev) begin
      if (src_q.size() != 0 && (!src_rand || $urandom_range(3) != 0)) begin
        itvalid = 1'b1;
        {itkeep, itdata} = src_q[0];
      end else itvalid = 1'b0;
    end
    rdy_prev = itready;
    if (!gnt_rand) tx_gnt = 1'b1;
    else if (!tx_req) begin
      tx_gnt = 1'b0;
      gdelay = $urandom_range(5);
    end else if (tx_gnt) begin
      if ($urandom_range(29) == 0) begin
        tx_gnt = 1'b0;
        gdelay = $urandom_range(3);
      end
    end else if (gdelay > 0) gdelay--;
    else tx_gnt = 1'b1;
    ftdi_txe_n = txe_rand ? ($urandom_range(9) < 3) : 1'b0;
  endtask

  // Called right after reset release; n back-to-back words with grant tied high and chip ready.
  task automatic directed_burst(input int n, input logic [7:0] b0);
    logic [W-1:0] wd[$];
    logic [7:0]   b;
    gnt_rand = 0; txe_rand = 0; src_rand = 0;
    for (int k = 0; k < n; k++) begin
      b = 8'(int'(b0) * (k + 1));
      wd.push_back({8'(b + 3), 8'(b + 2), 8'(b + 1), b});
      src_q.push_back({{BYTES{1'b1}}, wd[k]});
    end
    step();
    chk("rdy_after_rst", itready, 1);
    for (int c = 0; c < n + 5; c++) begin
      step();
      chk($sformatf("req_c%0d", c), tx_req, (c >= 1 && c <= n + 2));
      chk($sformatf("oe_c%0d", c), ftdi_oe, (c >= 2 && c <= n + 2));
      chk($sformatf("wrn_c%0d", c), ftdi_wr_n, !(c >= 3 && c <= n + 2));
      if (c >= 3 && c <= n + 2) chk($sformatf("data_c%0d", c), ftdi_data, wd[c-3]);
    end
  endtask

  task automatic drain(input int budget);
    int t;
    t = 0;
    while ((src_q.size() != 0 || model_q.size() != 0 || tx_req) && t < budget) begin
      step();
      t++;
    end
    step();
    chk("drain_done", t < budget, 1);
  endtask

  function automatic word_t rnd_word();
    logic [BYTES-1:0] k;
    int sel;
    sel = $urandom_range(7);
    k = (sel == 0) ? 4'h0 : (sel == 1) ? 4'hF : 4'($urandom_range(15));
    return {k, 32'($urandom)};
  endfunction

  initial begin
    int t;
    int wr0;
    int exp_b[3];
    exp_b = '{4, 4, 2};
    rstn = 1'b0; itvalid = 1'b0; itdata = '0; itkeep = '0;
    tx_gnt = 1'b0; ftdi_txe_n = 1'b1;
    repeat (3) @(posedge iclk);
    @(negedge iclk); #2; rstn = 1'b1;

    directed_burst(3, 8'h11);

    // Reset in the middle of a burst, then a fresh single word.
    for (int k = 0; k < 4; k++) src_q.push_back({{BYTES{1'b1}}, 32'hDEAD_0000 + 32'(k)});
    t = 0;
    do begin
      step();
      t++;
    end while (ftdi_wr_n && t < 50);
    chk("pre_rst_wr", ftdi_wr_n, 0);
    step();
    @(posedge iclk); #3; rstn = 1'b0; #1;
    chk("async_rst", {ftdi_wr_n, ftdi_oe, tx_req}, 3'b100);
    src_q.delete(); itvalid = 1'b0; rdy_prev = 1'b0;
    repeat (2) @(posedge iclk);
    @(negedge iclk); #2; rstn = 1'b1;
    directed_burst(1, 8'h5A);

    // Ten words against the burst limit.
    burst_log.delete();
    for (int k = 0; k < 10; k++) src_q.push_back({{BYTES{1'b1}}, 32'hB000_0000 + 32'(k)});
    drain(200);
    chk("burst_cnt", burst_log.size(), 3);
    for (int i = 0; i < 3; i++)
      chk($sformatf("burst_%0d", i), (i < burst_log.size()) ? burst_log[i] : -1, exp_b[i]);

    // Byte-enable handling.
    wr0 = n_writes;
    src_q.push_back({4'b1111, 32'hC0C1C2C3});
    src_q.push_back({4'b0011, 32'hD0D1D2D3});
    src_q.push_back({4'b0000, 32'hE0E1E2E3});
    drain(200);
    chk("keep_writes", n_writes - wr0, BE_EN ? 2 : 3);

    // Random traffic: random valid gaps, keep masks, grant delays/drops and chip back-pressure.
    gnt_rand = 1; txe_rand = 1; src_rand = 1;
    for (int i = 0; i < 3000; i++) begin
      step();
      if (src_q.size() < 6 && $urandom_range(1) == 1) src_q.push_back(rnd_word());
    end
    src_rand = 0; txe_rand = 0;
    drain(3000);
    chk("final_empty", model_q.size(), 0);
    chk("final_idle", {tx_req, ftdi_oe, ftdi_wr_n}, 3'b001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule
